mm_burst_bridge: RTL
====================

Name: mm_burst_bridge

Overview:
- Sits directly downstream of the L1 cache's main-memory port.
- Converts one 256-bit line eviction (mm_write) or line fill (mm_read) into a fixed-length burst on a narrow Avalon-MM-style memory bus with waitrequest and readdatavalid.
- For fills, reassembles the returned beats into a full line and presents it to the cache with a one-cycle mm_readdata_valid pulse.

Parameters:
- LINE_BITS, 256, cache line width in bits.
- BUS_BITS, 32, memory bus data width; legal values are 32 and 64.
- BEATS (localparam), LINE_BITS/BUS_BITS, beats per burst; 8 at the defaults.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mm_a  in  32  line address from the cache; bits [4:0] ignored
- mm_be  in  32  line byte enables from the cache
- mm_wd  in  256  eviction line data
- mm_write  in  1  eviction request, level-held by the cache
- mm_read  in  1  fill request, level-held by the cache
- mm_rd  out  256  assembled fill line
- mm_readdata_valid  out  1  fill complete, one-cycle pulse
- mm_write_done  out  1  eviction complete, one-cycle pulse
- mm_busy  out  1  high whenever state is not IDLE
- avl_address  out  32  burst base address, {line_addr[31:5],5'b0}
- avl_burstcount  out  4  equals BEATS while avl_read or avl_write is high, else 0
- avl_read  out  1  read burst command
- avl_write  out  1  write beat valid
- avl_writedata  out  BUS_BITS  current write beat
- avl_byteenable  out  BUS_BITS/8  byte enables for the current beat
- avl_waitrequest  in  1  memory stall
- avl_readdata  in  BUS_BITS  read beat data
- avl_readdatavalid  in  1  read beat valid

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE; beat counter 0; mm_rd 0; all strobes/commands 0; avl_address 0; avl_burstcount 0.
- Reset mid-burst: next edge forces IDLE and drops every command. Latched line data and partial beats are discarded. avl_readdatavalid seen outside RD_DATA is ignored.
- States: IDLE, WR_BURST, RD_CMD, RD_DATA, DONE.
- IDLE sampling: requests are sampled only in IDLE. On entry to a burst, latch mm_a[31:5], mm_wd and mm_be.
  - mm_write=1 -> WR_BURST (write has priority when both requests are high; the fill is then taken on a later IDLE).
  - else mm_read=1 -> RD_CMD.
- WR_BURST:
  - avl_write=1, avl_burstcount=BEATS.
  - avl_writedata = latched line slice [beat*BUS_BITS +: BUS_BITS].
  - avl_byteenable = matching mm_be slice.
  - Beat counter advances only when avl_waitrequest=0. Acceptance of beat BEATS-1 -> DONE with mm_write_done=1.
- RD_CMD: avl_read=1, avl_burstcount=BEATS, held until a cycle with avl_waitrequest=0, then -> RD_DATA.
- RD_DATA:
  - Each avl_readdatavalid=1 beat writes avl_readdata into line slice [beat*BUS_BITS +: BUS_BITS] and increments the counter.
  - Beats arrive in order; gaps are allowed.
  - Beat BEATS-1 -> DONE with mm_readdata_valid=1; mm_rd carries the new line.
- DONE:
  - Exactly one cycle; the completion strobe is high only here; requests are ignored; then -> IDLE.
  - The cache must drop its request in the cycle after the strobe.
- mm_rd: updated only on fill beats; holds its value afterwards until the next fill overwrites slices.
- Beat counter: width clog2(BEATS); wraps to 0 on entry to DONE.
- Minimum latency, zero wait states:
  - Write: request sampled in cycle 0, beats in cycles 1..8, mm_write_done in cycle 9.
  - Read: request sampled in cycle 0, avl_read in cycle 1, first beat no earlier than cycle 2, mm_readdata_valid in the cycle after the last beat.
- Requests arriving while not in IDLE are neither lost nor queued. They are seen only if still held when IDLE returns.

Test Plan:
- Write burst: mm_write=1, mm_a=32'h0004_1234, mm_wd = words 8'h7..0 pattern 32'h1111_1111*(i+1), mm_be all ones, no waitrequest -> avl_address=32'h0004_1220, burstcount=8, beats i=0..7 carry 32'h1111_1111*(i+1) in cycles 1..8, mm_write_done single pulse in cycle 9.
- Read with gaps: mm_read=1, mm_a=32'h0000_0040, waitrequest=1 for 3 cycles, then 8 beats 32'hA0..A7 separated by idle cycles -> avl_read held 4 cycles; mm_rd[31:0]=32'hA0, mm_rd[255:224]=32'hA7; mm_readdata_valid one cycle after beat 7.
- Write stalls: waitrequest toggled 1,0,1,0 during beats -> each beat held stable while stalled; exactly 8 accepted beats, no duplicates.
- Simultaneous requests: mm_read=mm_write=1 in IDLE -> write burst completes first (mm_write_done), then read burst starts the cycle after IDLE, mm_readdata_valid follows.
- Reset mid-fill: reset=1 after beat 3 of a read -> next cycle state IDLE, mm_busy=0, avl_read=0, no mm_readdata_valid. The remaining 4 stray readdatavalid beats do not alter mm_rd.
- Byte enables: mm_be=32'h0000_F00F, write burst -> avl_byteenable = 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 0, 0 on beats 0..7.

Source files
------------

// File: rtl/mm_burst_bridge.sv
// Bridges the cache main-memory port (one 256-bit line per request) onto a
// narrow Avalon-MM style burst bus; fills are reassembled into mm_rd.
module mm_burst_bridge #(
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned BUS_BITS  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             mm_a,
  input  logic [LINE_BITS/8-1:0]  mm_be,
  input  logic [LINE_BITS-1:0]    mm_wd,
  input  logic                    mm_write,
  input  logic                    mm_read,
  output logic [LINE_BITS-1:0]    mm_rd,
  output logic                    mm_readdata_valid,
  output logic                    mm_write_done,
  output logic                    mm_busy,
  output logic [31:0]             avl_address,
  output logic [3:0]              avl_burstcount,
  output logic                    avl_read,
  output logic                    avl_write,
  output logic [BUS_BITS-1:0]     avl_writedata,
  output logic [BUS_BITS/8-1:0]   avl_byteenable,
  input  logic                    avl_waitrequest,
  input  logic [BUS_BITS-1:0]     avl_readdata,
  input  logic                    avl_readdatavalid
);

  localparam int unsigned BEATS    = LINE_BITS / BUS_BITS;
  localparam int unsigned BE_BITS  = BUS_BITS / 8;
  localparam int unsigned LBE_BITS = LINE_BITS / 8;
  localparam int unsigned CNT_W    = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BURST = 3'd1,
    RD_CMD   = 3'd2,
    RD_DATA  = 3'd3,
    DONE     = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       beat_q, beat_d;
  logic [26:0]            addr_q, addr_d;
  logic [LINE_BITS-1:0]   wline_q, wline_d;
  logic [LBE_BITS-1:0]    be_q, be_d;
  logic [LINE_BITS-1:0]   rd_q, rd_d;
  logic                   rdv_q, rdv_d;
  logic                   wdone_q, wdone_d;
  logic                   busy_q, busy_d;
  logic [31:0]            avl_addr_q, avl_addr_d;
  logic [3:0]             bc_q, bc_d;
  logic                   avl_rd_q, avl_rd_d;
  logic                   avl_wr_q, avl_wr_d;
  logic [BUS_BITS-1:0]    wdata_q, wdata_d;
  logic [BE_BITS-1:0]     bytee_q, bytee_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    be_d    = be_q;
    rd_d    = rd_q;
    rdv_d   = 1'b0;
    wdone_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (mm_write || mm_read) begin
          addr_d  = mm_a[31:5];
          wline_d = mm_wd;
          be_d    = mm_be;
          beat_d  = '0;
          state_d = mm_write ? WR_BURST : RD_CMD;
        end
      end
      WR_BURST: begin
        if (!avl_waitrequest) begin
          if (beat_q == CNT_W'(BEATS - 1)) begin
            beat_d  = '0;
            wdone_d = 1'b1;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      RD_CMD: begin
        if (!avl_waitrequest) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (avl_readdatavalid) begin
          rd_d[beat_q*BUS_BITS +: BUS_BITS] = avl_readdata;
          if (beat_q == CNT_W'(BEATS - 1)) begin
            beat_d  = '0;
            rdv_d   = 1'b1;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs follow the state being entered so they line up with it.
    busy_d     = (state_d != IDLE);
    avl_wr_d   = (state_d == WR_BURST);
    avl_rd_d   = (state_d == RD_CMD);
    bc_d       = (avl_wr_d || avl_rd_d) ? 4'(BEATS) : 4'd0;
    avl_addr_d = {addr_d, 5'b0};
    wdata_d    = avl_wr_d ? wline_d[beat_d*BUS_BITS +: BUS_BITS] : '0;
    bytee_d    = avl_wr_d ? be_d[beat_d*BE_BITS +: BE_BITS] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      addr_q     <= '0;
      wline_q    <= '0;
      be_q       <= '0;
      rd_q       <= '0;
      rdv_q      <= 1'b0;
      wdone_q    <= 1'b0;
      busy_q     <= 1'b0;
      avl_addr_q <= '0;
      bc_q       <= '0;
      avl_rd_q   <= 1'b0;
      avl_wr_q   <= 1'b0;
      wdata_q    <= '0;
      bytee_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      wline_q    <= wline_d;
      be_q       <= be_d;
      rd_q       <= rd_d;
      rdv_q      <= rdv_d;
      wdone_q    <= wdone_d;
      busy_q     <= busy_d;
      avl_addr_q <= avl_addr_d;
      bc_q       <= bc_d;
      avl_rd_q   <= avl_rd_d;
      avl_wr_q   <= avl_wr_d;
      wdata_q    <= wdata_d;
      bytee_q    <= bytee_d;
    end
  end

  assign mm_rd             = rd_q;
  assign mm_readdata_valid = rdv_q;
  assign mm_write_done     = wdone_q;
  assign mm_busy           = busy_q;
  assign avl_address       = avl_addr_q;
  assign avl_burstcount    = bc_q;
  assign avl_read          = avl_rd_q;
  assign avl_write         = avl_wr_q;
  assign avl_writedata     = wdata_q;
  assign avl_byteenable    = bytee_q;

endmodule
